// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port controller: round-robin between the cam and gfx requesters,
// with an optional full-frame clear engine compiled in when FB_CLEAR_EN is defined.
//
// state | meaning
// IDLE  | arbitrate cam/gfx requesters onto the buffer write port
// CLEAR | write the latched colour to every pixel, one address per cycle
module fb_write_arbiter #(
   parameter int AW    = 15,
   parameter int DW    = 16,
   parameter int DEPTH = 19200
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cam_valid,
   output logic          cam_ready,
   input  logic [AW-1:0] cam_addr,
   input  logic [DW-1:0] cam_data,
   input  logic          gfx_valid,
   output logic          gfx_ready,
   input  logic [AW-1:0] gfx_addr,
   input  logic [DW-1:0] gfx_data,
   input  logic          clear_start,
   input  logic [DW-1:0] clear_color,
   output logic          clear_busy,
   output logic          clear_done,
   output logic          fb_we,
   output logic [AW-1:0] fb_wAddr,
   output logic [DW-1:0] fb_wData,
   output logic          oob_err
);

   localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
   localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);
   localparam logic          GNT_CAM = 1'b0;
   localparam logic          GNT_GFX = 1'b1;

   logic          last_grant_q;
   logic          fb_we_q;
   logic [AW-1:0] fb_waddr_q;
   logic [DW-1:0] fb_wdata_q;
   logic          oob_err_q;

   logic          arb_en;
   logic          cam_win;
   logic          gfx_win;
   logic          xfer;
   logic [AW-1:0] xfer_addr;
   logic [DW-1:0] xfer_data;

   logic          fb_we_d;
   logic [AW-1:0] fb_waddr_d;
   logic [DW-1:0] fb_wdata_d;
   logic          oob_set;

`ifdef FB_CLEAR_EN
   typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

   state_t        state_q;
   logic [AW-1:0] clr_cnt_q;
   logic [DW-1:0] clr_color_q;
   logic          clear_busy_q;
   logic          clear_done_q;

   // clear_start takes the port away from both requesters in the same cycle it arrives
   assign arb_en     = (state_q == ST_IDLE) & ~clear_start;
   assign clear_busy = clear_busy_q;
   assign clear_done = clear_done_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         clr_cnt_q    <= '0;
         clr_color_q  <= '0;
         clear_busy_q <= 1'b0;
         clear_done_q <= 1'b0;
      end else begin
         clear_done_q <= 1'b0;
         if (state_q == ST_IDLE) begin
            if (clear_start) begin
               state_q      <= ST_CLEAR;
               clr_cnt_q    <= '0;
               clr_color_q  <= clear_color;
               clear_busy_q <= 1'b1;
            end
         end else begin
            if (clr_cnt_q == LAST_A) begin
               state_q      <= ST_IDLE;
               clear_busy_q <= 1'b0;
               clear_done_q <= 1'b1;
            end else begin
               clr_cnt_q <= clr_cnt_q + AW'(1);
            end
         end
      end
   end
`else
   logic unused_clear;

   assign arb_en       = 1'b1;
   assign clear_busy   = 1'b0;
   assign clear_done   = 1'b0;
   assign unused_clear = ^{clear_start, clear_color};
`endif

   // On a tie the requester that did not win last time goes first
   assign cam_win   = cam_valid & (~gfx_valid | (last_grant_q == GNT_GFX));
   assign gfx_win   = gfx_valid & (~cam_valid | (last_grant_q == GNT_CAM));
   assign cam_ready = arb_en & cam_win;
   assign gfx_ready = arb_en & gfx_win;
   assign xfer      = cam_ready | gfx_ready;
   assign xfer_addr = cam_ready ? cam_addr : gfx_addr;
   assign xfer_data = cam_ready ? cam_data : gfx_data;

   always_comb begin
      fb_we_d    = xfer & (xfer_addr < DEPTH_A);
      oob_set    = xfer & (xfer_addr >= DEPTH_A);
      fb_waddr_d = xfer_addr;
      fb_wdata_d = xfer_data;
`ifdef FB_CLEAR_EN
      if (state_q == ST_CLEAR) begin
         fb_we_d    = 1'b1;
         fb_waddr_d = clr_cnt_q;
         fb_wdata_d = clr_color_q;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_grant_q <= GNT_GFX;
         fb_we_q      <= 1'b0;
         fb_waddr_q   <= '0;
         fb_wdata_q   <= '0;
         oob_err_q    <= 1'b0;
      end else begin
         fb_we_q <= fb_we_d;
         if (fb_we_d) begin
            fb_waddr_q <= fb_waddr_d;
            fb_wdata_q <= fb_wdata_d;
         end
         if (xfer) begin
            last_grant_q <= gfx_ready;
         end
         if (oob_set) begin
            oob_err_q <= 1'b1;
         end
      end
   end

   assign fb_we    = fb_we_q;
   assign fb_wAddr = fb_waddr_q;
   assign fb_wData = fb_wdata_q;
   assign oob_err  = oob_err_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter: random and directed requester traffic plus
// clear sequences, checked against a cycle-level behavioural model of the write port.
module tb_fb_write_arbiter;
   localparam int AW    = 15;
   localparam int DW    = 16;
   localparam int DEPTH = 19200;
`ifdef FB_CLEAR_EN
   localparam bit CLR_EN = 1'b1;
`else
   localparam bit CLR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          cam_valid = 1'b0, gfx_valid = 1'b0;
   logic          cam_ready, gfx_ready;
   logic [AW-1:0] cam_addr = '0, gfx_addr = '0;
   logic [DW-1:0] cam_data = '0, gfx_data = '0;
   logic          clear_start = 1'b0;
   logic [DW-1:0] clear_color = '0;
   logic          clear_busy, clear_done, fb_we, oob_err;
   logic [AW-1:0] fb_wAddr;
   logic [DW-1:0] fb_wData;

   fb_write_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n),
      .cam_valid(cam_valid), .cam_ready(cam_ready), .cam_addr(cam_addr), .cam_data(cam_data),
      .gfx_valid(gfx_valid), .gfx_ready(gfx_ready), .gfx_addr(gfx_addr), .gfx_data(gfx_data),
      .clear_start(clear_start), .clear_color(clear_color),
      .clear_busy(clear_busy), .clear_done(clear_done),
      .fb_we(fb_we), .fb_wAddr(fb_wAddr), .fb_wData(fb_wData), .oob_err(oob_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            tag;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;
   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } tx_t;

   wr_t sb_q[$];
   tx_t cam_txq[$], gfx_txq[$];

   int checks = 0, failures = 0;
   int cyc = 0;
   int done_seen = 0;
   bit cam_acc = 1'b0, gfx_acc = 1'b0;
   bit cam_rnd_en = 1'b0, gfx_rnd_en = 1'b0;
   int cam_rate = 100, gfx_rate = 100;

   // model state: who won last, sticky error, clear progress
   int            m_last = 1;
   bit            m_oob = 1'b0;
   bit            m_clr = 1'b0;
   int            m_cnt = 0;
   logic [DW-1:0] m_color = '0;
   bit            exp_busy[4] = '{0, 0, 0, 0};
   bit            exp_done[4] = '{0, 0, 0, 0};
   bit            exp_oob[4]  = '{0, 0, 0, 0};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 9) == 0) return AW'($urandom_range(DEPTH, 32767));
      return AW'($urandom_range(0, DEPTH - 1));
   endfunction

   // Reference model: decides readies for this cycle and predicts next-cycle outputs
   bit            m_ec, m_eg, m_blocked;
   int            m_nxt, m_a;
   logic [DW-1:0] m_d;
   always @(negedge clk) begin
      cam_acc   = cam_valid && cam_ready;
      gfx_acc   = gfx_valid && gfx_ready;
      m_ec      = 1'b0;
      m_eg      = 1'b0;
      m_nxt     = (cyc + 1) % 4;
      m_blocked = m_clr || (CLR_EN && clear_start);
      if (!m_blocked) begin
         if (cam_valid && gfx_valid) begin
            if (m_last == 1) m_ec = 1'b1;
            else m_eg = 1'b1;
         end else begin
            m_ec = cam_valid;
            m_eg = gfx_valid;
         end
      end
      check("cam_ready", 32'(cam_ready), 32'(m_ec));
      check("gfx_ready", 32'(gfx_ready), 32'(m_eg));
      if (!reset_n) begin
         m_last = 1;
         m_oob  = 1'b0;
         m_clr  = 1'b0;
         m_cnt  = 0;
         exp_busy[m_nxt] = 1'b0;
         exp_done[m_nxt] = 1'b0;
         exp_oob[m_nxt]  = 1'b0;
      end else begin
         exp_done[m_nxt] = 1'b0;
         if (m_clr) begin
            sb_q.push_back('{cyc + 1, AW'(m_cnt), m_color});
            if (m_cnt == DEPTH - 1) begin
               m_clr = 1'b0;
               exp_done[m_nxt] = 1'b1;
            end else begin
               m_cnt++;
            end
         end else if (CLR_EN && clear_start) begin
            m_clr   = 1'b1;
            m_cnt   = 0;
            m_color = clear_color;
         end else if (m_ec || m_eg) begin
            m_a    = m_ec ? int'(cam_addr) : int'(gfx_addr);
            m_d    = m_ec ? cam_data : gfx_data;
            m_last = m_ec ? 0 : 1;
            if (m_a < DEPTH) sb_q.push_back('{cyc + 1, AW'(m_a), m_d});
            else m_oob = 1'b1;
         end
         exp_busy[m_nxt] = m_clr;
         exp_oob[m_nxt]  = m_oob;
      end
   end

   // Monitor: compares whatever the DUT presents against the scoreboard
   initial begin : monitor
      wr_t w;
      int  idx;
      forever begin
         @(negedge clk);
         #1;
         if (cyc >= 2) begin
            idx = cyc % 4;
            if (fb_we) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_write cycle=%0d actual addr=%0d data=0x%0h expected no write",
                           cyc, fb_wAddr, fb_wData);
               end else begin
                  w = sb_q.pop_front();
                  check("wr_cycle", 32'(cyc), 32'(w.tag));
                  check("wr_addr", 32'(fb_wAddr), 32'(w.addr));
                  check("wr_data", 32'(fb_wData), 32'(w.data));
               end
            end else if (sb_q.size() > 0 && sb_q[0].tag <= cyc) begin
               w = sb_q.pop_front();
               checks++;
               failures++;
               $display("FAIL missing_write cycle=%0d actual fb_we=0 expected addr=%0d data=0x%0h",
                        cyc, w.addr, w.data);
            end
            check("clear_busy", 32'(clear_busy), 32'(exp_busy[idx]));
            check("clear_done", 32'(clear_done), 32'(exp_done[idx]));
            check("oob_err", 32'(oob_err), 32'(exp_oob[idx]));
            if (clear_done) done_seen++;
         end
      end
   end

   // Requester driver: holds a request until accepted, then takes the next one
   initial begin : driver
      tx_t t;
      forever begin
         @(posedge clk);
         #1;
         if (!cam_valid || cam_acc) begin
            if (cam_txq.size() > 0) begin
               t = cam_txq.pop_front();
               cam_valid = 1'b1; cam_addr = t.addr; cam_data = t.data;
            end else if (cam_rnd_en && $urandom_range(0, 99) < cam_rate) begin
               cam_valid = 1'b1; cam_addr = rand_addr(); cam_data = DW'($urandom);
            end else begin
               cam_valid = 1'b0;
            end
         end
         if (!gfx_valid || gfx_acc) begin
            if (gfx_txq.size() > 0) begin
               t = gfx_txq.pop_front();
               gfx_valid = 1'b1; gfx_addr = t.addr; gfx_data = t.data;
            end else if (gfx_rnd_en && $urandom_range(0, 99) < gfx_rate) begin
               gfx_valid = 1'b1; gfx_addr = rand_addr(); gfx_data = DW'($urandom);
            end else begin
               gfx_valid = 1'b0;
            end
         end
      end
   end

   task automatic wait_idle(input int bound);
      int n = 0;
      while ((cam_txq.size() > 0 || gfx_txq.size() > 0 || cam_valid || gfx_valid) && n < bound) begin
         tick(1);
         n++;
      end
      checks++;
      if (n >= bound) begin
         failures++;
         $display("FAIL wait_idle cycle=%0d actual still busy after %0d cycles expected drained", cyc, n);
      end
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      tick(2);
      check("rst_fb_we", 32'(fb_we), 32'd0);
      check("rst_fb_wAddr", 32'(fb_wAddr), 32'd0);
      check("rst_fb_wData", 32'(fb_wData), 32'd0);
      reset_n = 1'b1;
   endtask

   task automatic pulse_clear(input logic [DW-1:0] color);
      clear_start = 1'b1;
      clear_color = color;
      tick(1);
      clear_start = 1'b0;
      clear_color = DW'($urandom);
   endtask

   initial begin : main
      int  d0;
      bit  found;
      tick(3);
      check("rst_clear_busy", 32'(clear_busy), 32'd0);
      check("rst_clear_done", 32'(clear_done), 32'd0);
      check("rst_oob_err", 32'(oob_err), 32'd0);
      apply_reset();

      // cam-only stream, addresses 0..9
      for (int i = 0; i < 10; i++) cam_txq.push_back('{AW'(i), DW'(16'h1000 + i)});
      wait_idle(60);

      // both requesters contending straight after reset: cam must win first
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         cam_txq.push_back('{AW'(100 + i), DW'(16'hA000 + i)});
         gfx_txq.push_back('{AW'(200 + i), DW'(16'hB000 + i)});
      end
      wait_idle(60);

      // out-of-range address followed by a legal one; error stays until reset
      cam_txq.push_back('{AW'(DEPTH), 16'hDEAD});
      cam_txq.push_back('{AW'(5), 16'h1005});
      wait_idle(30);
      tick(10);
      apply_reset();

      // random traffic; clear pulses only stress the build without the clear engine
      cam_rnd_en = 1'b1;
      gfx_rnd_en = 1'b1;
      for (int c = 0; c < 4; c++) begin
         cam_rate = $urandom_range(20, 100);
         gfx_rate = $urandom_range(20, 100);
         repeat (750) begin
            tick(1);
            clear_start = !CLR_EN && ($urandom_range(0, 31) == 0);
            clear_color = DW'($urandom);
         end
         clear_start = 1'b0;
      end
      cam_rnd_en = 1'b0;
      gfx_rnd_en = 1'b0;
      wait_idle(100);

      cam_rate   = 100;
      gfx_rate   = 100;
      cam_rnd_en = 1'b1;
      gfx_rnd_en = 1'b1;
      tick(5);
`ifdef FB_CLEAR_EN
      // full clear under contention, with a stray second start mid-way
      d0 = done_seen;
      pulse_clear(16'hF800);
      tick(500);
      pulse_clear(16'h1234);
      tick(DEPTH);
      tick(20);
      check("clear_done_count", 32'(done_seen - d0), 32'd1);

      // reset while write 100 is on the port, then a fresh clear from address 0
      d0 = done_seen;
      pulse_clear(16'h07E0);
      found = 1'b0;
      for (int n = 0; n < 300 && !found; n++) begin
         tick(1);
         if (fb_we && fb_wAddr == AW'(100)) found = 1'b1;
      end
      check("found_write_100", 32'(found), 32'd1);
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      check("abort_clear_busy", 32'(clear_busy), 32'd0);
      check("abort_fb_we", 32'(fb_we), 32'd0);
      tick(5);
      check("abort_no_done", 32'(done_seen - d0), 32'd0);
      pulse_clear(16'h001F);
      tick(DEPTH + 20);
      check("restart_done_count", 32'(done_seen - d0), 32'd1);
`else
      d0 = done_seen;
      pulse_clear(16'hF800);
      tick(40);
      check("noclr_busy", 32'(clear_busy), 32'd0);
      check("noclr_done_count", 32'(done_seen - d0), 32'd0);
`endif
      cam_rnd_en = 1'b0;
      gfx_rnd_en = 1'b0;
      wait_idle(100);
      tick(5);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
